wb_arbiter_2: RTL and testbench

- Two-master Wishbone (pipelined, classic-stall) arbiter sharing one Wishbone slave port, typically the single-cycle memory slave, between two requesters.
- Grants the bus per cycle-phase (a full wb_cyc burst), round-robin on contention.
- Routes stall/ack/data back to the owning master only.
- Sits between two masters (e.g. CPU and DMA) and the memory slave.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arbiter_2.sv | 114 +++++++++++
 tb/tb_wb_arbiter_2.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: grant-state encoding and
// master index constants.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage : wb_arb_pkg

// File: rtl/wb_arbiter_2.sv
// Two-master pipelined Wishbone arbiter: grants one whole wb_cyc burst at a
// time, round-robin on contention, with one IDLE cycle between owners.
module wb_arbiter_2
  import wb_arb_pkg::*;
#(
  parameter int G_ADDR_SIZE = 8,
  parameter int G_DATA_SIZE = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // master 0
  input  logic                   s0_wb_cyc_i,
  output logic                   s0_wb_stall_o,
  input  logic                   s0_wb_stb_i,
  output logic                   s0_wb_ack_o,
  input  logic                   s0_wb_we_i,
  input  logic [G_ADDR_SIZE-1:0] s0_wb_addr_i,
  input  logic [G_DATA_SIZE-1:0] s0_wb_data_i,
  output logic [G_DATA_SIZE-1:0] s0_wb_data_o,
  // master 1
  input  logic                   s1_wb_cyc_i,
  output logic                   s1_wb_stall_o,
  input  logic                   s1_wb_stb_i,
  output logic                   s1_wb_ack_o,
  input  logic                   s1_wb_we_i,
  input  logic [G_ADDR_SIZE-1:0] s1_wb_addr_i,
  input  logic [G_DATA_SIZE-1:0] s1_wb_data_i,
  output logic [G_DATA_SIZE-1:0] s1_wb_data_o,
  // shared slave
  output logic                   m_wb_cyc_o,
  input  logic                   m_wb_stall_i,
  output logic                   m_wb_stb_o,
  input  logic                   m_wb_ack_i,
  output logic                   m_wb_we_o,
  output logic [G_ADDR_SIZE-1:0] m_wb_addr_o,
  output logic [G_DATA_SIZE-1:0] m_wb_data_o,
  input  logic [G_DATA_SIZE-1:0] m_wb_data_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= MASTER1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A grant is only issued from IDLE, so a handover always costs one dead
  // cycle and a stale slave ack can never reach the new owner.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (s0_wb_cyc_i && (!s1_wb_cyc_i || last_q == MASTER1)) begin
          state_d = GRANT0;
          last_d  = MASTER0;
        end else if (s1_wb_cyc_i) begin
          state_d = GRANT1;
          last_d  = MASTER1;
        end
      end
      GRANT0:  if (!s0_wb_cyc_i) state_d = IDLE;
      GRANT1:  if (!s1_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_wb_cyc_o    = 1'b0;
    m_wb_stb_o    = 1'b0;
    m_wb_we_o     = 1'b0;
    m_wb_addr_o   = '0;
    m_wb_data_o   = '0;
    s0_wb_stall_o = 1'b1;
    s0_wb_ack_o   = 1'b0;
    s0_wb_data_o  = '0;
    s1_wb_stall_o = 1'b1;
    s1_wb_ack_o   = 1'b0;
    s1_wb_data_o  = '0;
    unique case (state_q)
      GRANT0: begin
        m_wb_cyc_o    = s0_wb_cyc_i;
        m_wb_stb_o    = s0_wb_stb_i;
        m_wb_we_o     = s0_wb_we_i;
        m_wb_addr_o   = s0_wb_addr_i;
        m_wb_data_o   = s0_wb_data_i;
        s0_wb_stall_o = m_wb_stall_i;
        s0_wb_ack_o   = m_wb_ack_i;
        s0_wb_data_o  = m_wb_data_i;
      end
      GRANT1: begin
        m_wb_cyc_o    = s1_wb_cyc_i;
        m_wb_stb_o    = s1_wb_stb_i;
        m_wb_we_o     = s1_wb_we_i;
        m_wb_addr_o   = s1_wb_addr_i;
        m_wb_data_o   = s1_wb_data_i;
        s1_wb_stall_o = m_wb_stall_i;
        s1_wb_ack_o   = m_wb_ack_i;
        s1_wb_data_o  = m_wb_data_i;
      end
      default: ;
    endcase
  end

endmodule : wb_arbiter_2

// File: tb/tb_wb_arbiter_2.sv
// Bench for wb_arbiter_2: directed scenarios then random traffic, checked
// every cycle against an ownership model plus a small memory slave.
module tb_wb_arbiter_2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  cyc_v, stb_v, we_v;
  logic [7:0]  addr_v [2];
  logic [15:0] wdata_v [2];
  logic        s0_stall, s0_ack, s1_stall, s1_ack;
  logic [15:0] s0_rdata, s1_rdata;
  logic        m_cyc, m_stb, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;

  // slave environment
  logic        slv_stall = 1'b0;
  int          ack_lat = 1;
  logic        acc1 = 1'b0, acc2 = 1'b0;
  logic [15:0] rd1 = '0, rd2 = '0;
  logic [15:0] mem [256];
  logic        m_ack;
  logic [15:0] m_rdata;

  // reference model: current owner (-1 = none) and last granted index
  int own, last;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_2 #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s0_wb_cyc_i  (cyc_v[0]),
    .s0_wb_stall_o(s0_stall),
    .s0_wb_stb_i  (stb_v[0]),
    .s0_wb_ack_o  (s0_ack),
    .s0_wb_we_i   (we_v[0]),
    .s0_wb_addr_i (addr_v[0]),
    .s0_wb_data_i (wdata_v[0]),
    .s0_wb_data_o (s0_rdata),
    .s1_wb_cyc_i  (cyc_v[1]),
    .s1_wb_stall_o(s1_stall),
    .s1_wb_stb_i  (stb_v[1]),
    .s1_wb_ack_o  (s1_ack),
    .s1_wb_we_i   (we_v[1]),
    .s1_wb_addr_i (addr_v[1]),
    .s1_wb_data_i (wdata_v[1]),
    .s1_wb_data_o (s1_rdata),
    .m_wb_cyc_o   (m_cyc),
    .m_wb_stall_i (slv_stall),
    .m_wb_stb_o   (m_stb),
    .m_wb_ack_i   (m_ack),
    .m_wb_we_o    (m_we),
    .m_wb_addr_o  (m_addr),
    .m_wb_data_o  (m_wdata),
    .m_wb_data_i  (m_rdata)
  );

  // Single-port memory slave, ack latency 1 or 2 cycles after acceptance.
  always @(posedge clk_i) begin
    if (m_cyc && m_stb && !slv_stall && m_we) mem[m_addr] <= m_wdata;
    acc1 <= m_cyc && m_stb && !slv_stall;
    rd1  <= mem[m_addr];
    acc2 <= acc1;
    rd2  <= rd1;
  end
  assign m_ack   = (ack_lat == 2) ? acc2 : acc1;
  assign m_rdata = (ack_lat == 2) ? rd2 : rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] v0, input logic [31:0] v1);
    return (own == 0) ? v0 : (own == 1) ? v1 : 32'd0;
  endfunction

  // Expected outputs follow directly from who owns the bus.
  task automatic compare_all();
    chk("m_cyc",   m_cyc,   pick(cyc_v[0], cyc_v[1]));
    chk("m_stb",   m_stb,   pick(stb_v[0], stb_v[1]));
    chk("m_we",    m_we,    pick(we_v[0], we_v[1]));
    chk("m_addr",  m_addr,  pick(addr_v[0], addr_v[1]));
    chk("m_wdata", m_wdata, pick(wdata_v[0], wdata_v[1]));
    chk("s0_stall", s0_stall, (own == 0) ? slv_stall : 1'b1);
    chk("s1_stall", s1_stall, (own == 1) ? slv_stall : 1'b1);
    chk("s0_ack",   s0_ack,   (own == 0) ? m_ack : 1'b0);
    chk("s1_ack",   s1_ack,   (own == 1) ? m_ack : 1'b0);
    chk("s0_rdata", s0_rdata, (own == 0) ? m_rdata : 16'h0);
    chk("s1_rdata", s1_rdata, (own == 1) ? m_rdata : 16'h0);
    chk("one_ack",  s0_ack & s1_ack, 0);
    chk("stb_cyc",  m_stb & ~m_cyc, 0);
  endtask

  task automatic sample();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic model_reset();
    own  = -1;
    last = 1;
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else if (own < 0) begin
      if (cyc_v == 2'b11) own = 1 - last;
      else if (cyc_v[0])  own = 0;
      else if (cyc_v[1])  own = 1;
      if (own >= 0) last = own;
    end else if (!cyc_v[own]) own = -1;
    #1;
  endtask

  task automatic cyc_step();
    sample();
    advance();
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    model_reset();
    cyc_step();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_i = 1'b1;
    cyc_v = '0; stb_v = '0; we_v = '0;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    model_reset();
    cyc_step();
    cyc_step();
    rst_i = 1'b0;
    cyc_step();

    // s0 alone writes 0xBEEF to 0x12
    cyc_v[0] = 1; stb_v[0] = 1; we_v[0] = 1; addr_v[0] = 8'h12; wdata_v[0] = 16'hBEEF;
    sample(); chk("t1_idle_cyc", m_cyc, 0); advance();
    sample(); chk("t1_grant_addr", m_addr, 8'h12); chk("t1_s1_stall", s1_stall, 1); advance();
    stb_v[0] = 0;
    sample(); chk("t1_s0_ack", s0_ack, 1); advance();
    cyc_v[0] = 0; we_v[0] = 0;
    cyc_step();
    cyc_step();

    // tie after reset goes to master 0; s0 reads back, then s1 gets the bus
    pulse_reset();
    cyc_v = 2'b11; stb_v[0] = 1; addr_v[0] = 8'h12; addr_v[1] = 8'h55;
    cyc_step();
    sample(); chk("t2_grant0", m_addr, 8'h12); advance();
    stb_v[0] = 0;
    sample(); chk("t2_s0_ack", s0_ack, 1); chk("t2_s0_data", s0_rdata, 16'hBEEF);
    chk("t2_s1_ack", s1_ack, 0); advance();
    cyc_v[0] = 0;
    cyc_step();
    sample(); chk("t2_idle_gap", m_cyc, 0); advance();
    sample(); chk("t2_grant1", m_addr, 8'h55); chk("t2_s1_stall", s1_stall, 0); advance();
    cyc_v[1] = 0;
    cyc_step();
    cyc_step();

    // back-to-back contending bursts alternate 0,1,0,1 with one dead cycle
    cyc_v = 2'b11;
    for (int r = 0; r < 8; r++) begin
      int e;
      e = r % 2;
      addr_v[0] = 8'h20 + 8'(r); addr_v[1] = 8'h40 + 8'(r);
      sample(); chk("t3_idle_gap", m_cyc, 0); advance();
      stb_v[e] = 1; we_v[e] = 1; wdata_v[e] = 16'(r);
      sample(); chk("t3_rr_grant", m_addr, (e == 0) ? 8'h20 + 8'(r) : 8'h40 + 8'(r)); advance();
      stb_v[e] = 0; we_v[e] = 0;
      sample(); chk("t3_ack", (e == 0) ? s0_ack : s1_ack, 1); advance();
      cyc_v[e] = 0;
      cyc_step();
      cyc_v[e] = 1;
    end
    cyc_v = 2'b00;
    cyc_step();

    // aborted s1 request: slave ack lands in IDLE and is dropped
    ack_lat = 2;
    cyc_v[1] = 1; stb_v[1] = 1; addr_v[1] = 8'h12;
    cyc_step();
    cyc_step();
    cyc_v[1] = 0; stb_v[1] = 0;
    cyc_step();
    sample(); chk("t4_stale_ack_seen", m_ack, 1);
    chk("t4_s0_ack", s0_ack, 0); chk("t4_s1_ack", s1_ack, 0); advance();
    ack_lat = 1;
    cyc_step();

    // slave stalls three cycles during GRANT1
    cyc_v[1] = 1;
    cyc_step();
    stb_v[1] = 1; we_v[1] = 1; addr_v[1] = 8'h33; wdata_v[1] = 16'h1234; slv_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("t5_s1_stall", s1_stall, 1); chk("t5_s0_stall", s0_stall, 1);
      chk("t5_m_addr", m_addr, 8'h33); advance();
    end
    slv_stall = 0;
    sample(); chk("t5_s1_unstall", s1_stall, 0); advance();
    stb_v[1] = 0; we_v[1] = 0;
    sample(); chk("t5_s1_ack", s1_ack, 1); advance();
    cyc_v[1] = 0;
    cyc_step();
    cyc_step();

    // asynchronous reset in the middle of an s0 burst
    cyc_v[0] = 1; stb_v[0] = 1; addr_v[0] = 8'h77;
    cyc_step();
    sample(); chk("t6_granted", m_cyc, 1);
    #2 rst_i = 1'b1;
    model_reset();
    #1 compare_all(); chk("t6_rst_cyc", m_cyc, 0); chk("t6_rst_addr", m_addr, 0);
    advance();
    rst_i = 1'b0;
    cyc_v = 2'b11; stb_v = 2'b00; addr_v[1] = 8'h66;
    cyc_step();
    sample(); chk("t6_tie_grant0", m_addr, 8'h77); advance();
    cyc_v = 2'b00;
    cyc_step();
    cyc_step();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!cyc_v[n]) cyc_v[n] = ($urandom_range(3) == 0);
        else if ($urandom_range(5) == 0) cyc_v[n] = 1'b0;
        stb_v[n]   = cyc_v[n] & $urandom_range(1);
        we_v[n]    = 1'($urandom_range(1));
        addr_v[n]  = 8'($urandom);
        wdata_v[n] = 16'($urandom);
      end
      slv_stall = ($urandom_range(3) == 0);
      ack_lat   = (c % 200 < 100) ? 1 : 2;
      cyc_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_wb_arbiter_2
